// File: rtl/velocity_pkg.sv
// Shared constants and the saturation helper for the velocity write path.
package velocity_pkg;

  localparam int ARB_FIXED         = 0;
  localparam int ARB_RR            = 1;
  localparam int DEFAULT_VEL_WIDTH = 11;

  // Clamp v to +/-vmax. vmax is also limited to the largest positive code of
  // a 'width'-bit signed value, so the result always fits back into 'width'
  // bits. The most-negative code therefore clamps to -vmax.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int width,
                                                  input int vmax);
    int cap;
    int lim;
    cap = (1 << (width - 1)) - 1;
    lim = (vmax > cap) ? cap : vmax;
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/velocity_arb_pick.sv
// Combinational grant picker: fixed priority (lowest index wins) or
// round-robin starting at the rr pointer with wrap-around.
module velocity_arb_pick
  import velocity_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int MODE    = ARB_FIXED,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] cand_i,
  input  logic [IDX_W-1:0]   rr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               valid_o
);

  int start;
  int j;

  // Scan candidates from the start point; the first one found wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    start       = (MODE == ARB_RR) ? int'(rr_i) : 0;
    j           = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = start + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!valid_o && cand_i[j]) begin
        valid_o     = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/velocity_arbiter.sv
// Multi-source velocity write arbiter: one saturated commit per cycle,
// losing updates parked in per-source pending slots (newest wins).
module velocity_arbiter
  import velocity_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_VEL_WIDTH,
  parameter int NUM_SRC = 2,
  parameter int MODE    = ARB_FIXED,
  parameter int VMAX    = 1000,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*WIDTH-1:0]   in_vx,
  input  logic [NUM_SRC*WIDTH-1:0]   in_vy,
  input  logic                       flush,
  input  logic                       overrun_clr,
  output logic signed [WIDTH-1:0]    out_vx,
  output logic signed [WIDTH-1:0]    out_vy,
  output logic                       write_enable,
  output logic [IDX_W-1:0]           grant_idx,
  output logic [NUM_SRC-1:0]         pending,
  output logic [NUM_SRC-1:0]         overrun
);

  function automatic logic signed [WIDTH-1:0] sat_v(input logic signed [WIDTH-1:0] v);
    logic signed [31:0] wide;
    wide = {{(32-WIDTH){v[WIDTH-1]}}, v};
    return WIDTH'(saturate(wide, WIDTH, VMAX));
  endfunction

  logic signed [WIDTH-1:0] slot_vx_q [NUM_SRC];
  logic signed [WIDTH-1:0] slot_vy_q [NUM_SRC];
  logic signed [WIDTH-1:0] slot_vx_d [NUM_SRC];
  logic signed [WIDTH-1:0] slot_vy_d [NUM_SRC];
  logic signed [WIDTH-1:0] req_vx    [NUM_SRC];
  logic signed [WIDTH-1:0] req_vy    [NUM_SRC];
  logic [NUM_SRC-1:0]      pend_q, pend_d;
  logic [NUM_SRC-1:0]      ovr_q, ovr_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic signed [WIDTH-1:0] out_vx_q, out_vx_d;
  logic signed [WIDTH-1:0] out_vy_q, out_vy_d;
  logic                    we_q, we_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;

  logic [NUM_SRC-1:0]      cand;
  logic [NUM_SRC-1:0]      pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic signed [WIDTH-1:0] sel_vx, sel_vy;

  // A flush removes every candidate, which also suppresses this cycle's commit.
  assign cand = flush ? '0 : (req | pend_q);

  velocity_arb_pick #(
    .NUM_SRC (NUM_SRC),
    .MODE    (MODE)
  ) u_pick (
    .cand_i      (cand),
    .rr_i        (rr_q),
    .grant_o     (pick_grant),
    .grant_idx_o (pick_idx),
    .valid_o     (pick_valid)
  );

  // Unpack the flat input buses and select the winner's data (fresh request
  // data takes precedence over a parked slot).
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_vx[i] = in_vx[i*WIDTH +: WIDTH];
      req_vy[i] = in_vy[i*WIDTH +: WIDTH];
    end
    sel_vx = req[pick_idx] ? req_vx[pick_idx] : slot_vx_q[pick_idx];
    sel_vy = req[pick_idx] ? req_vy[pick_idx] : slot_vy_q[pick_idx];
  end

  // Next-state for slots, overrun flags, commit registers and rr pointer.
  always_comb begin
    slot_vx_d = slot_vx_q;
    slot_vy_d = slot_vy_q;
    pend_d    = pend_q;
    ovr_d     = overrun_clr ? '0 : ovr_q;
    out_vx_d  = out_vx_q;
    out_vy_d  = out_vy_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    we_d      = pick_valid;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flush || pick_grant[i]) begin
        pend_d[i] = 1'b0;
      end else if (req[i]) begin
        slot_vx_d[i] = req_vx[i];
        slot_vy_d[i] = req_vy[i];
        pend_d[i]    = 1'b1;
        if (pend_q[i]) ovr_d[i] = 1'b1;
      end
    end
    if (pick_valid) begin
      out_vx_d = sat_v(sel_vx);
      out_vy_d = sat_v(sel_vy);
      gidx_d   = pick_idx;
      if (MODE == ARB_RR)
        rr_d = (int'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + 1'b1;
    end
  end

  // State registers; reset clears everything, including parked slot data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_vx_q[i] <= '0;
        slot_vy_q[i] <= '0;
      end
      pend_q   <= '0;
      ovr_q    <= '0;
      rr_q     <= '0;
      out_vx_q <= '0;
      out_vy_q <= '0;
      we_q     <= 1'b0;
      gidx_q   <= '0;
    end else begin
      slot_vx_q <= slot_vx_d;
      slot_vy_q <= slot_vy_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      rr_q      <= rr_d;
      out_vx_q  <= out_vx_d;
      out_vy_q  <= out_vy_d;
      we_q      <= we_d;
      gidx_q    <= gidx_d;
    end
  end

  assign out_vx       = out_vx_q;
  assign out_vy       = out_vy_q;
  assign write_enable = we_q;
  assign grant_idx    = gidx_q;
  assign pending      = pend_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_velocity_arbiter.sv
// Bench: two instances (2 sources fixed priority, 3 sources round-robin)
// checked against a behavioural scoreboard model plus directed constants.
module tb_velocity_arbiter;

  localparam int WA = 12;
  localparam int WB = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] t_req [2];
  int         t_vx  [2][8];
  int         t_vy  [2][8];
  logic       t_fl  [2];
  logic       t_oc  [2];

  logic [1:0]        a_req;
  logic [2*WA-1:0]   a_vx, a_vy;
  logic [2:0]        b_req;
  logic [3*WB-1:0]   b_vx, b_vy;

  always_comb begin
    a_req = t_req[0][1:0];
    b_req = t_req[1][2:0];
    a_vx = '0; a_vy = '0; b_vx = '0; b_vy = '0;
    for (int k = 0; k < 2; k++) begin
      a_vx[k*WA +: WA] = WA'(t_vx[0][k]);
      a_vy[k*WA +: WA] = WA'(t_vy[0][k]);
    end
    for (int k = 0; k < 3; k++) begin
      b_vx[k*WB +: WB] = WB'(t_vx[1][k]);
      b_vy[k*WB +: WB] = WB'(t_vy[1][k]);
    end
  end

  logic signed [WA-1:0] a_ox, a_oy;
  logic signed [WB-1:0] b_ox, b_oy;
  logic                 a_we, b_we;
  logic                 a_gi;
  logic [1:0]           b_gi;
  logic [1:0]           a_pend, a_ovr;
  logic [2:0]           b_pend, b_ovr;

  velocity_arbiter #(.WIDTH(WA), .NUM_SRC(2), .MODE(0), .VMAX(1000)) dut_a (
    .clk(clk), .reset(reset), .req(a_req), .in_vx(a_vx), .in_vy(a_vy),
    .flush(t_fl[0]), .overrun_clr(t_oc[0]), .out_vx(a_ox), .out_vy(a_oy),
    .write_enable(a_we), .grant_idx(a_gi), .pending(a_pend), .overrun(a_ovr));

  velocity_arbiter #(.WIDTH(WB), .NUM_SRC(3), .MODE(1), .VMAX(1000)) dut_b (
    .clk(clk), .reset(reset), .req(b_req), .in_vx(b_vx), .in_vy(b_vy),
    .flush(t_fl[1]), .overrun_clr(t_oc[1]), .out_vx(b_ox), .out_vy(b_oy),
    .write_enable(b_we), .grant_idx(b_gi), .pending(b_pend), .overrun(b_ovr));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int inst; int we; int vx; int vy; int gi; int pend; int ovr;} exp_t;
  exp_t q[$];

  int m_pend [2][8];
  int m_sx   [2][8];
  int m_sy   [2][8];
  int m_rr [2], m_ovr [2], m_ox [2], m_oy [2], m_gi [2];

  function automatic int sat(input int v);
    if (v > 1000) return 1000;
    if (v < -1000) return -1000;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        m_pend[i][k] = 0; m_sx[i][k] = 0; m_sy[i][k] = 0;
      end
      m_rr[i] = 0; m_ovr[i] = 0; m_ox[i] = 0; m_oy[i] = 0; m_gi[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int n, g, j, sets, pm;
    exp_t e;
    n = (i == 0) ? 2 : 3;
    g = -1;
    sets = 0;
    if (t_fl[i]) begin
      for (int k = 0; k < n; k++) m_pend[i][k] = 0;
    end else begin
      for (int k = 0; k < n; k++) begin
        j = (i == 0) ? k : (m_rr[i] + k) % n;
        if (g < 0 && (t_req[i][j] || m_pend[i][j] != 0)) g = j;
      end
      if (g >= 0) begin
        m_ox[i] = sat(t_req[i][g] ? t_vx[i][g] : m_sx[i][g]);
        m_oy[i] = sat(t_req[i][g] ? t_vy[i][g] : m_sy[i][g]);
        m_gi[i] = g;
        if (i == 1) m_rr[i] = (g + 1) % n;
        m_pend[i][g] = 0;
      end
      for (int k = 0; k < n; k++) begin
        if (k != g && t_req[i][k]) begin
          if (m_pend[i][k] != 0) sets = sets | (1 << k);
          m_pend[i][k] = 1;
          m_sx[i][k] = t_vx[i][k];
          m_sy[i][k] = t_vy[i][k];
        end
      end
    end
    if (t_oc[i]) m_ovr[i] = 0;
    m_ovr[i] = m_ovr[i] | sets;
    pm = 0;
    for (int k = 0; k < n; k++) pm = pm | (m_pend[i][k] << k);
    e = '{i, (g >= 0) ? 1 : 0, m_ox[i], m_oy[i], m_gi[i], pm, m_ovr[i]};
    q.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    repeat (2) begin
      if (q.size() == 0) begin
        chk("sb.empty", 0, 1);
      end else begin
        e = q.pop_front();
        if (e.inst == 0) begin
          chk("A.we", a_we, e.we);  chk("A.vx", a_ox, e.vx);  chk("A.vy", a_oy, e.vy);
          chk("A.gi", a_gi, e.gi);  chk("A.pend", a_pend, e.pend); chk("A.ovr", a_ovr, e.ovr);
        end else begin
          chk("B.we", b_we, e.we);  chk("B.vx", b_ox, e.vx);  chk("B.vy", b_oy, e.vy);
          chk("B.gi", b_gi, e.gi);  chk("B.pend", b_pend, e.pend); chk("B.ovr", b_ovr, e.ovr);
        end
      end
    end
  endtask

  // Inputs are set at posedge+1; the model predicts the next edge's result.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      t_req[i] = '0; t_fl[i] = 1'b0; t_oc[i] = 1'b0;
    end
  endtask

  task automatic set_src(input int i, input int k, input int vx, input int vy);
    t_vx[i][k] = vx;
    t_vy[i][k] = vy;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".A.vx"}, a_ox, 0);  chk({tag, ".A.we"}, a_we, 0);
    chk({tag, ".A.pend"}, a_pend, 0);  chk({tag, ".A.ovr"}, a_ovr, 0);
    chk({tag, ".B.vx"}, b_ox, 0);  chk({tag, ".B.vy"}, b_oy, 0);
    chk({tag, ".B.we"}, b_we, 0);  chk({tag, ".B.gi"}, b_gi, 0);
    chk({tag, ".B.pend"}, b_pend, 0);  chk({tag, ".B.ovr"}, b_ovr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  int held;

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) set_src(i, k, 0, 0);
    model_reset();
    #12;
    check_all_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Two simultaneous requests drain over two cycles, then hold
    t_req[0] = 8'b11; set_src(0, 0, 100, -50); set_src(0, 1, 7, 8);
    cycle();
    chk("t1.vx0", a_ox, 100); chk("t1.vy0", a_oy, -50); chk("t1.gi0", a_gi, 0); chk("t1.we0", a_we, 1);
    idle_inputs();
    cycle();
    chk("t1.vx1", a_ox, 7); chk("t1.vy1", a_oy, 8); chk("t1.gi1", a_gi, 1); chk("t1.we1", a_we, 1);
    cycle();
    chk("t1.we2", a_we, 0); chk("t1.hold", a_ox, 7);

    // Saturation, including the most-negative code on instance B
    t_req[0] = 8'b01; set_src(0, 0, 1500, -1024);
    t_req[1] = 8'b100; set_src(1, 2, -1024, 1000);
    cycle();
    chk("sat.vx", a_ox, 1000); chk("sat.vy", a_oy, -1000);
    chk("sat.bvx", b_ox, -1000); chk("sat.bvy", b_oy, 1000);
    idle_inputs();
    cycle();

    // Overrun: slot 1 overwritten while source 0 keeps winning
    t_req[0] = 8'b11; set_src(0, 0, 1, 1); set_src(0, 1, 5, 5);
    cycle();
    set_src(0, 0, 2, 2); set_src(0, 1, 3, 3);
    cycle();
    chk("ovr.flag", a_ovr, 2);
    idle_inputs();
    cycle();
    chk("ovr.vx", a_ox, 3); chk("ovr.gi", a_gi, 1);
    t_oc[0] = 1'b1;
    cycle();
    chk("ovr.clr", a_ovr, 0);
    idle_inputs();

    // Request on a source whose pending slot is granted the same cycle
    t_req[0] = 8'b11; set_src(0, 0, 10, 10); set_src(0, 1, 20, 20);
    cycle();
    t_req[0] = 8'b10; set_src(0, 1, 30, 30);
    cycle();
    chk("same.vx", a_ox, 30); chk("same.pend", a_pend, 0); chk("same.ovr", a_ovr, 0);
    idle_inputs();

    // Round-robin with all three sources requesting for six cycles
    for (int c = 0; c < 6; c++) begin
      t_req[1] = 8'b111;
      for (int k = 0; k < 3; k++) set_src(1, k, 10 * c + k, -(10 * c + k));
      cycle();
      chk("rr.gi", b_gi, c % 3);
      chk("rr.we", b_we, 1);
    end
    idle_inputs();
    repeat (3) cycle();

    // Build pending=100 then flush with req=011
    t_req[1] = 8'b001; set_src(1, 0, 11, 12);
    cycle();
    t_req[1] = 8'b110; set_src(1, 1, 21, 22); set_src(1, 2, 31, 32);
    cycle();
    chk("fl.pre", b_pend, 4);
    held = b_ox;
    t_req[1] = 8'b011; t_fl[1] = 1'b1;
    cycle();
    chk("fl.we", b_we, 0); chk("fl.pend", b_pend, 0); chk("fl.hold", b_ox, held);
    idle_inputs();
    cycle();

    // Reset mid-drain with pending=110
    t_req[1] = 8'b100; set_src(1, 2, 40, 41);
    cycle();
    t_req[1] = 8'b111; set_src(1, 0, 50, 51); set_src(1, 1, 60, 61); set_src(1, 2, 70, 71);
    cycle();
    chk("mid.pend", b_pend, 6);
    idle_inputs();
    reset = 1'b1;
    #1;
    check_all_zero("mid");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      cycle();
      chk("post.we", b_we, 0);
    end

    // Randomised traffic on both instances
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 2; i++) begin
        t_req[i] = 8'($urandom_range(0, 7));
        t_fl[i]  = ($urandom_range(0, 9) == 0);
        t_oc[i]  = ($urandom_range(0, 7) == 0);
        for (int k = 0; k < 3; k++) begin
          if (i == 0) set_src(i, k, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
          else        set_src(i, k, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
        end
      end
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
